// File: rtl/stream_demux_pkg.sv
// stream_demux_pkg: shared constants and helpers for the 1-to-N stream demux.
package stream_demux_pkg;
    localparam int DROP_CNT_W = 8;
    localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;
    function automatic int sel_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/demux_ch_slot.sv
// demux_ch_slot: one-entry output register slice that can load while draining.
module demux_ch_slot #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [DW-1:0] din,
    input  logic          ready,
    output logic          valid,
    output logic [DW-1:0] dout,
    output logic          can_take
);
    assign can_take = !valid | ready;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            dout  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            dout  <= din;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/stream_demux_1xn.sv
// stream_demux_1xn: registered 1-to-N valid/ready demux with broadcast and drop counting.
module stream_demux_1xn
    import stream_demux_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int DW    = 8,
    parameter int SEL_W = sel_w(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DW-1:0]         in_data,
    input  logic [SEL_W-1:0]      in_sel,
    input  logic                  in_bcast,
    output logic [N_CH-1:0]       out_valid,
    input  logic [N_CH-1:0]       out_ready,
    output logic [N_CH*DW-1:0]    out_data,
    output logic [DROP_CNT_W-1:0] drop_cnt
);
    localparam logic [SEL_W:0] N_LIM = (SEL_W + 1)'(N_CH);
    logic [N_CH-1:0] can_take, load;
    logic sel_ok, accept;
    // Out-of-range selects are always accepted so they never stall the producer.
    assign sel_ok   = {1'b0, in_sel} < N_LIM;
    assign in_ready = in_bcast ? &can_take : (sel_ok ? can_take[in_sel] : 1'b1);
    assign accept   = in_valid & in_ready;
    genvar k;
    generate
        for (k = 0; k < N_CH; k++) begin : g_ch
            assign load[k] = accept & (in_bcast | (sel_ok & (in_sel == SEL_W'(k))));
            demux_ch_slot #(.DW(DW)) u_slot (
                .clk      (clk),
                .rst_n    (rst_n),
                .load     (load[k]),
                .din      (in_data),
                .ready    (out_ready[k]),
                .valid    (out_valid[k]),
                .dout     (out_data[k*DW +: DW]),
                .can_take (can_take[k])
            );
        end
    endgenerate
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) drop_cnt <= '0;
        else if (accept && !in_bcast && !sel_ok && drop_cnt != DROP_CNT_MAX) drop_cnt <= drop_cnt + 1'b1;
    end
endmodule

// File: tb/tb_stream_demux_1xn.sv
// tb_stream_demux_1xn: randomized and directed checks against a per-channel mailbox model.
module tb_stream_demux_1xn;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        a_in_valid, a_in_ready, a_in_bcast;
    logic [7:0]  a_in_data;
    logic [1:0]  a_in_sel;
    logic [3:0]  a_out_valid, a_out_ready;
    logic [31:0] a_out_data;
    logic [7:0]  a_drop_cnt;

    logic        b_in_valid, b_in_ready, b_in_bcast;
    logic [7:0]  b_in_data;
    logic [1:0]  b_in_sel;
    logic [2:0]  b_out_valid, b_out_ready;
    logic [23:0] b_out_data;
    logic [7:0]  b_drop_cnt;

    stream_demux_1xn #(.N_CH(4), .DW(8)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .in_sel(a_in_sel), .in_bcast(a_in_bcast),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .drop_cnt(a_drop_cnt)
    );
    stream_demux_1xn #(.N_CH(3), .DW(8)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .in_sel(b_in_sel), .in_bcast(b_in_bcast),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .drop_cnt(b_drop_cnt)
    );

    int checks = 0;
    int failures = 0;

    // Model: each channel is a mailbox holding at most one pending word.
    logic [7:0]  mq [4][$];
    logic        obs_rdy, exp_rdy;
    logic [3:0]  ev;
    logic [31:0] ed, em;

    task automatic model_clear();
        for (int k = 0; k < 4; k++) mq[k].delete();
        ev = '0; ed = '0; em = '0;
    endtask

    // Called just after a rising edge; returns just after the next rising edge.
    task automatic cyc4(input bit v, input logic [1:0] sel, input bit bc,
                        input logic [7:0] dat, input logic [3:0] rdy);
        bit room [4];
        a_in_valid = v; a_in_sel = sel; a_in_bcast = bc; a_in_data = dat; a_out_ready = rdy;
        #3;
        for (int k = 0; k < 4; k++) room[k] = (mq[k].size() == 0) || rdy[k];
        exp_rdy = bc ? (room[0] && room[1] && room[2] && room[3]) : room[sel];
        obs_rdy = a_in_ready;
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) if (mq[k].size() != 0 && rdy[k]) void'(mq[k].pop_front());
        if (v && exp_rdy) for (int k = 0; k < 4; k++) if (bc || sel == k) mq[k].push_back(dat);
        ev = '0; ed = '0; em = '0;
        for (int k = 0; k < 4; k++) if (mq[k].size() != 0) begin
            ev[k] = 1'b1; ed[k*8 +: 8] = mq[k][0]; em[k*8 +: 8] = 8'hFF;
        end
    endtask

    task automatic test_reset();
        a_in_valid = 0; a_in_sel = 0; a_in_bcast = 0; a_in_data = 0; a_out_ready = 0;
        b_in_valid = 0; b_in_sel = 0; b_in_bcast = 0; b_in_data = 0; b_out_ready = 0;
        rst_n = 0;
        model_clear();
        repeat (2) @(posedge clk);
        #3;
        checks++;
        if (a_out_valid !== 4'b0000 || a_out_data !== 32'h0 || a_drop_cnt !== 8'd0 || a_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset4: valid=%b data=%h drop=%0d rdy=%b, want 0000/0/0/1", a_out_valid, a_out_data, a_drop_cnt, a_in_ready);
        end
        a_in_bcast = 1; b_in_bcast = 1; #1;
        checks++;
        if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1 || b_out_valid !== 3'b000 || b_drop_cnt !== 8'd0) begin
            failures++;
            $display("FAIL reset_bcast: rdy4=%b rdy3=%b valid3=%b drop3=%0d, want 1/1/000/0", a_in_ready, b_in_ready, b_out_valid, b_drop_cnt);
        end
        a_in_bcast = 0; b_in_bcast = 0;
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_stream();
        for (int k = 0; k < 4; k++) begin
            cyc4(1, 2'(k), 0, 8'hA0 + 8'(k), 4'hF);
            checks++;
            if (obs_rdy !== 1'b1 || a_out_valid !== 4'(1 << k) || a_out_data[k*8 +: 8] !== 8'hA0 + 8'(k)) begin
                failures++;
                $display("FAIL stream ch%0d: rdy=%b valid=%b data=%h, want 1/%b/%h", k, obs_rdy, a_out_valid, a_out_data[k*8 +: 8], 4'(1 << k), 8'hA0 + 8'(k));
            end
        end
        cyc4(0, 0, 0, 0, 4'hF);
        checks++;
        if (a_out_valid !== 4'b0000) begin
            failures++;
            $display("FAIL stream_drain: valid=%b want 0000", a_out_valid);
        end
    endtask

    task automatic test_backpressure();
        cyc4(1, 2, 0, 8'h11, 4'b1011);
        checks++;
        if (obs_rdy !== 1'b1 || a_out_valid !== 4'b0100 || a_out_data[23:16] !== 8'h11) begin
            failures++;
            $display("FAIL bp_first: rdy=%b valid=%b data=%h, want 1/0100/11", obs_rdy, a_out_valid, a_out_data[23:16]);
        end
        for (int i = 0; i < 2; i++) begin
            cyc4(1, 2, 0, 8'h22, 4'b1011);
            checks++;
            if (obs_rdy !== 1'b0 || a_out_valid !== 4'b0100 || a_out_data[23:16] !== 8'h11) begin
                failures++;
                $display("FAIL bp_stall%0d: rdy=%b valid=%b data=%h, want 0/0100/11", i, obs_rdy, a_out_valid, a_out_data[23:16]);
            end
        end
        cyc4(1, 2, 0, 8'h22, 4'b1111);
        checks++;
        if (obs_rdy !== 1'b1 || a_out_valid !== 4'b0100 || a_out_data[23:16] !== 8'h22) begin
            failures++;
            $display("FAIL bp_swap: rdy=%b valid=%b data=%h, want 1/0100/22", obs_rdy, a_out_valid, a_out_data[23:16]);
        end
        cyc4(0, 0, 0, 0, 4'hF);
    endtask

    task automatic test_bcast();
        cyc4(1, 1, 0, 8'h33, 4'b1101);
        cyc4(1, 0, 1, 8'h5A, 4'b1101);
        checks++;
        if (obs_rdy !== 1'b0 || a_out_valid !== 4'b0010 || a_out_data[15:8] !== 8'h33) begin
            failures++;
            $display("FAIL bcast_block: rdy=%b valid=%b data1=%h, want 0/0010/33", obs_rdy, a_out_valid, a_out_data[15:8]);
        end
        cyc4(1, 0, 1, 8'h5A, 4'b1111);
        checks++;
        if (obs_rdy !== 1'b1 || a_out_valid !== 4'b1111 || a_out_data !== 32'h5A5A5A5A) begin
            failures++;
            $display("FAIL bcast_all: rdy=%b valid=%b data=%h, want 1/1111/5a5a5a5a", obs_rdy, a_out_valid, a_out_data);
        end
        cyc4(0, 0, 0, 0, 4'hF);
    endtask

    task automatic test_random();
        logic v = 0, bc = 0;
        logic [1:0] sel = 0;
        logic [7:0] dat = 0;
        bit hold = 0;
        for (int i = 0; i < 400; i++) begin
            if (!hold) begin
                v = ($urandom_range(0, 3) != 0);
                bc = ($urandom_range(0, 4) == 0);
                sel = 2'($urandom);
                dat = 8'($urandom);
            end
            cyc4(v, sel, bc, dat, 4'($urandom));
            hold = v && !exp_rdy;
            checks++;
            if (obs_rdy !== exp_rdy || a_out_valid !== ev || (a_out_data & em) !== ed || a_drop_cnt !== 8'd0) begin
                failures++;
                $display("FAIL random[%0d]: rdy=%b/%b valid=%b/%b data=%h/%h drop=%0d/0", i, obs_rdy, exp_rdy, a_out_valid, ev, a_out_data & em, ed, a_drop_cnt);
            end
        end
        cyc4(0, 0, 0, 0, 4'hF);
    endtask

    task automatic test_drop();
        int bad = 0;
        b_in_valid = 1; b_in_sel = 3; b_in_bcast = 0; b_out_ready = 3'b111;
        for (int i = 0; i < 300; i++) begin
            b_in_data = 8'($urandom);
            #3;
            if (b_in_ready !== 1'b1) bad++;
            @(posedge clk); #1;
            if (b_out_valid !== 3'b000 || b_drop_cnt !== 8'((i + 1 > 255) ? 255 : i + 1)) bad++;
        end
        b_in_valid = 0;
        checks++;
        if (bad != 0 || b_drop_cnt !== 8'd255) begin
            failures++;
            $display("FAIL drop_sat: bad_cycles=%0d drop=%0d, want 0/255", bad, b_drop_cnt);
        end
        b_in_valid = 1; b_in_sel = 2; b_in_data = 8'hC3; b_out_ready = 3'b000;
        @(posedge clk); #1;
        b_in_valid = 0;
        checks++;
        if (b_out_valid !== 3'b100 || b_out_data[23:16] !== 8'hC3 || b_drop_cnt !== 8'd255) begin
            failures++;
            $display("FAIL ch3_unicast: valid=%b data=%h drop=%0d, want 100/c3/255", b_out_valid, b_out_data[23:16], b_drop_cnt);
        end
    endtask

    task automatic test_async_reset();
        cyc4(1, 0, 1, 8'h77, 4'b0000);
        checks++;
        if (a_out_valid !== 4'b1111 || a_out_data !== 32'h77777777) begin
            failures++;
            $display("FAIL pre_reset_fill: valid=%b data=%h, want 1111/77777777", a_out_valid, a_out_data);
        end
        a_in_valid = 1; a_in_sel = 1; a_in_data = 8'h99;
        #2 rst_n = 0;
        #1;
        checks++;
        if (a_out_valid !== 4'b0000 || a_out_data !== 32'h0 || b_out_valid !== 3'b000 || b_drop_cnt !== 8'd0 || a_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL async_reset: valid4=%b data4=%h valid3=%b drop3=%0d rdy=%b, want 0000/0/000/0/1", a_out_valid, a_out_data, b_out_valid, b_drop_cnt, a_in_ready);
        end
        a_in_valid = 0;
        model_clear();
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;
        cyc4(1, 3, 0, 8'hE4, 4'b0000);
        checks++;
        if (obs_rdy !== 1'b1 || a_out_valid !== 4'b1000 || a_out_data[31:24] !== 8'hE4) begin
            failures++;
            $display("FAIL post_reset: rdy=%b valid=%b data=%h, want 1/1000/e4", obs_rdy, a_out_valid, a_out_data[31:24]);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_bcast();
        test_random();
        test_drop();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
